vga_tile_updater: RTL
=====================

# vga_tile_updater

Controller that sequences writes of the twelve 24-game card values into the VGA block's tile (glyph-index) memory. It watches `numbers_concat` and an explicit refresh request, then performs a full 12-entry rewrite only inside vertical blanking so the visible frame never tears. It sits between the game logic and the `vga` display datapath, driving the tile RAM write port, and retries a pass that blanking cut short.

## Interface
- `NUM_TILES`, 12: tiles per pass; nibble i of `numbers_concat` feeds tile i.
- `ADDR_W`, 4: tile address width; must satisfy 2^ADDR_W >= NUM_TILES.
- `clk_100m`  in  1  system clock, 100 MHz. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `numbers_concat`  in  4*NUM_TILES  card values; tile i = bits [4i+3:4i].
- `update_req`  in  1  one-cycle pulse forcing a rewrite even if values are unchanged.
- `vblank`  in  1  high during vertical blanking, from VGA timing, synchronous to `clk_100m`.
- `tile_ack`  in  1  tile RAM accepts the write when `tile_we && tile_ack` at a clock edge.
- `tile_we`  out  1  write strobe.
- `tile_addr`  out  ADDR_W  tile index 0..NUM_TILES-1.
- `tile_data`  out  4  glyph code, equal to the snapshot nibble.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse after a pass completes all writes.

## Operation
- States: IDLE, WAIT_BLANK, WRITE, DONE.
- `pending` flag: set by reset, by `update_req`, or whenever `numbers_concat != last_written`. Cleared on entry to WRITE. `update_req` or a value change during WRITE sets it again, so a second pass follows.
- IDLE: if `pending`, go to WAIT_BLANK next cycle.
- WAIT_BLANK: wait for a vblank rising edge, defined as `vblank==1 && vblank_d==0`, where `vblank_d` is `vblank` registered once. Entering while `vblank` is already high does not start a pass; the controller waits for the next frame's edge.
- On the edge: latch `snapshot <= numbers_concat`, set index 0, and go to WRITE.
- WRITE: drive `tile_we=1`, `tile_addr=index`, and `tile_data=snapshot[4*index+3:4*index]`.
  - On accept, increment index.
  - On accepting index NUM_TILES-1, go to DONE.
  - `tile_we` stays high across tiles while `tile_ack` stays high.
- Abort: if `vblank==0` is sampled in WRITE, next cycle `tile_we=0`, state is WAIT_BLANK, and `pending` is set. The next pass restarts at tile 0 with a fresh snapshot.
  - Abort beats accept: if `vblank` falls on the same edge as the final accept, this is an abort, not DONE.
- DONE: `done=1` for one cycle and `last_written <= snapshot`, then IDLE.
- Tile addresses are never written in any order other than 0..NUM_TILES-1 within a pass.

## Timing
- Reset values:
  - Outputs: `tile_we=0`, `tile_addr=0`, `tile_data=0`, `busy=0`, `done=0`.
  - Internal: state IDLE, `pending=1`, `last_written=0`, `vblank_d=1`. Because `vblank_d` resets to 1, a reset released mid-blank is not treated as an edge.
- All outputs are registered.
- Rising edge sampled at edge N: `tile_we` and `busy` are high from N+1, with `tile_addr=0`.
- With `tile_ack` tied high: addresses 0..11 on cycles N+1..N+12, `done` at N+13, `busy` low at N+14. The pass is 12 write cycles and 14 cycles edge-to-idle.
- With `tile_ack` low: `tile_we`, `tile_addr`, and `tile_data` hold stable. There is no timeout.
- `rst` mid-pass: outputs return to reset values at the next edge, and a full pass runs on the next qualifying blank.
- `update_req` while `busy`: it is not lost; exactly one additional pass follows.
- `numbers_concat` changes during WRITE: the current pass still writes the old snapshot.

## Test plan
- Reset, `numbers_concat=48'h0123_4567_89AB`, `tile_ack=1`, vblank rise at cycle 200 → writes to addr 0..11 with data B,A,9,…,0 on consecutive cycles, then one `done` pulse, then `busy` falls.
- No change and no `update_req` after a pass, with 3 vblank frames → `tile_we` never asserts and `busy` stays 0. Then pulse `update_req` → exactly one identical pass in the next blank.
- `tile_ack` low for 5 cycles at addr 4 → addr 4 with its data held stable for 6 cycles, then the pass continues. Total pass time is 17 write cycles.
- `vblank` drops after 7 accepts (addr 7 pending) → `tile_we` low next cycle and no `done`. The next frame's blank writes addr 0..11 again, with the snapshot taken at that edge.
- Change `numbers_concat` to `48'hFFF…F` at addr 5 mid-pass → the first pass finishes with old values and pulses `done`. A second pass on the next blank writes all F.
- Assert `rst` at addr 3 with `vblank` still high → outputs are zero next cycle and no pass starts in that blank. A full pass runs on the following vblank rise.

Source files
------------

// File: rtl/vga_tile_updater.sv
// rtl/vga_tile_updater.sv - sequences 12-tile rewrites of the VGA tile RAM inside vertical blanking
module vga_tile_updater #(
  parameter int NUM_TILES = 12,
  parameter int ADDR_W    = 4
) (
  input  logic                   clk_100m,
  input  logic                   rst,
  input  logic [4*NUM_TILES-1:0] numbers_concat,
  input  logic                   update_req,
  input  logic                   vblank,
  input  logic                   tile_ack,
  output logic                   tile_we,
  output logic [ADDR_W-1:0]      tile_addr,
  output logic [3:0]             tile_data,
  output logic                   busy,
  output logic                   done
);

  localparam int W = 4 * NUM_TILES;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TILES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BLANK, WRITE, DONE} state_t;

  state_t            state, state_n;
  logic              pending, pending_n;
  logic [W-1:0]      last_written;
  logic [W-1:0]      snapshot, snap_n;
  logic [W-1:0]      compare_ref;
  logic [W-1:0]      snap_shift;
  logic              vblank_d;
  logic              vblank_rise;
  logic              start, abort;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [3:0]        data_n;

  assign vblank_rise = vblank && !vblank_d;

  // While a pass is in flight the reference is the snapshot being written, so only
  // a genuine change during the pass queues a follow-up pass.
  assign compare_ref = (state == WRITE || state == DONE) ? snapshot : last_written;

  // Next-state logic; tile_addr doubles as the write index of the current pass.
  always_comb begin
    state_n = state;
    snap_n  = snapshot;
    we_n    = 1'b0;
    addr_n  = '0;
    start   = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (pending) state_n = WAIT_BLANK;
      end
      WAIT_BLANK: begin
        if (vblank_rise) begin
          state_n = WRITE;
          start   = 1'b1;
          snap_n  = numbers_concat;
          we_n    = 1'b1;
        end
      end
      WRITE: begin
        if (!vblank) begin
          // Leaving blanking wins over a simultaneous final accept.
          abort   = 1'b1;
          state_n = WAIT_BLANK;
        end else if (tile_ack) begin
          if (tile_addr == LAST_IDX) begin
            state_n = DONE;
          end else begin
            we_n   = 1'b1;
            addr_n = tile_addr + ADDR_W'(1);
          end
        end else begin
          we_n   = 1'b1;
          addr_n = tile_addr;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Glyph for the next registered write, and the pending-flag update.
  always_comb begin
    snap_shift = snap_n >> {addr_n, 2'b00};
    data_n     = we_n ? snap_shift[3:0] : 4'h0;
    if (start) pending_n = update_req;
    else       pending_n = pending | update_req | abort | (numbers_concat != compare_ref);
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= 1'b1;
      last_written <= '0;
      snapshot     <= '0;
      vblank_d     <= 1'b1;
      tile_we      <= 1'b0;
      tile_addr    <= '0;
      tile_data    <= 4'h0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      snapshot  <= snap_n;
      vblank_d  <= vblank;
      tile_we   <= we_n;
      tile_addr <= addr_n;
      tile_data <= data_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      if (state == DONE) last_written <= snapshot;
    end
  end

endmodule
